// File: rtl/led_breathe.sv
// Breathing-LED driver.
// Steps a brightness level up, holds it, steps it down and holds again, one
// move per prescaler tick. The level is rendered on led_o as a registered PWM
// waveform whose duty cycle only changes at period boundaries, so the output
// never glitches.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | parked dark, level 0; waits for en_i
// UP      | level rises by STEP per tick, saturating at LMAX
// HOLD_HI | level at LMAX; counts HOLD_TICKS ticks before fading down
// DOWN    | level falls by STEP per tick, saturating at 0
// HOLD_LO | level at 0; counts HOLD_TICKS ticks, then UP again or park

module led_breathe #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                tick_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic [2:0]          phase_o,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } phase_t;

    localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    localparam logic [PWM_BITS-1:0] LMAX     = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = LMAX - 1'b1;
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   LMAX_X   = {1'b0, LMAX};
    localparam logic [HOLD_W-1:0]   HOLD_X   = HOLD_W'(HOLD_TICKS);

    phase_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                led_q;

    // Saturating level arithmetic is done one bit wider so neither end wraps.
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   dn_diff;
    logic [PWM_BITS-1:0] level_up;
    logic [PWM_BITS-1:0] level_dn;
    logic [HOLD_W-1:0]   hold_inc;

    assign up_sum   = {1'b0, level_q} + STEP_X;
    assign dn_diff  = {1'b0, level_q} - STEP_X;
    assign level_up = (up_sum >= LMAX_X) ? LMAX : up_sum[PWM_BITS-1:0];
    assign level_dn = ({1'b0, level_q} <= STEP_X) ? '0 : dn_diff[PWM_BITS-1:0];
    assign hold_inc = hold_q + HOLD_W'(1);

    // State, level and hold counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            level_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: a tick moves either the level or the hold counter,
    // never both, and en_i dropping takes priority over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                level_d = '0;
                hold_d  = '0;
                if (en_i) begin
                    state_d = UP;
                end
            end
            UP: begin
                if (!en_i) begin
                    state_d = DOWN;
                end else if (tick_i) begin
                    level_d = level_up;
                    if (level_up == LMAX) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_HI: begin
                if (!en_i || (HOLD_TICKS == 0)) begin
                    state_d = DOWN;
                    hold_d  = '0;
                end else if (tick_i) begin
                    if (hold_inc == HOLD_X) begin
                        state_d = DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            DOWN: begin
                if (tick_i) begin
                    level_d = level_dn;
                    if (level_dn == '0) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_LO: begin
                if (!en_i) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (HOLD_TICKS == 0) begin
                    state_d = UP;
                    hold_d  = '0;
                end else if (tick_i) begin
                    if (hold_inc == HOLD_X) begin
                        state_d = UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Busy flag decoded straight from the state register.
    always_comb begin
        busy_o = (state_q != IDLE);
    end

    // PWM period counter 0..LMAX-1; duty is latched only at the period end so
    // a level change never produces a runt pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            if (pwm_cnt == PWM_LAST) begin
                pwm_cnt <= '0;
                duty    <= level_q;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Registered comparator output; duty=LMAX stays high since pwm_cnt < LMAX.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            led_q <= 1'b0;
        end else begin
            led_q <= (pwm_cnt < duty);
        end
    end

    assign led_o   = led_q;
    assign level_o = level_q;
    assign phase_o = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe at PWM_BITS=4 (LMAX=15), HOLD_TICKS=2.
// One instance uses STEP=1, a second uses STEP=4 for the saturation sequence.

module tb_led_breathe;

    logic       clk;
    logic       rst_n;
    logic       en, tick;
    logic       led, busy;
    logic [3:0] level;
    logic [2:0] phase;

    logic       en4, tick4;
    logic       led4, busy4;
    logic [3:0] level4;
    logic [2:0] phase4;

    int checks = 0;
    int errors = 0;

    led_breathe #(.PWM_BITS(4), .STEP(1), .HOLD_TICKS(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .tick_i  (tick),
        .led_o   (led),
        .level_o (level),
        .phase_o (phase),
        .busy_o  (busy)
    );

    led_breathe #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(2)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en4),
        .tick_i  (tick4),
        .led_o   (led4),
        .level_o (level4),
        .phase_o (phase4),
        .busy_o  (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic pulse4();
        tick4 = 1'b1;
        clk1();
        tick4 = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    // Count high samples and rising edges of led over n clocks.
    task automatic sample_led(input int n, output int hi, output int rises);
        logic prev;
        prev  = led;
        hi    = 0;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            clk1();
            if (led) hi++;
            if (led && !prev) rises++;
            prev = led;
        end
    endtask

    // From UP at level 0: 15 ticks, level 1..15, HOLD_HI after the last.
    task automatic ramp_up(input string pfx);
        for (int i = 1; i <= 15; i++) begin
            pulse();
            chk({pfx, "_up_level"}, level, i);
            chk({pfx, "_up_phase"}, phase, (i == 15) ? 2 : 1);
        end
    endtask

    initial begin
        int hi, rises;
        int up_lv[4];
        int dn_lv[4];
        up_lv = '{4, 8, 12, 15};
        dn_lv = '{11, 7, 3, 0};

        rst_n = 1'b0;
        en    = 1'b1;
        tick  = 1'b0;
        en4   = 1'b0;
        tick4 = 1'b0;

        // reset held with en high and tick toggling
        for (int i = 0; i < 3; i++) begin
            tick = (i % 2 == 0);
            clk1();
            chk("rst_led",   led,   0);
            chk("rst_level", level, 0);
            chk("rst_phase", phase, 0);
            chk("rst_busy",  busy,  0);
        end
        tick  = 1'b0;
        rst_n = 1'b1;
        clk1();
        chk("start_phase", phase, 1);
        chk("start_busy",  busy,  1);

        // full breathing cycle
        ramp_up("t2");
        pulse();
        chk("t2_hold1_phase", phase, 2);
        pulse();
        chk("t2_down_phase", phase, 3);
        chk("t2_down_level", level, 15);
        for (int i = 1; i <= 15; i++) begin
            pulse();
            chk("t2_dn_level", level, 15 - i);
            chk("t2_dn_phase", phase, (i == 15) ? 4 : 3);
        end
        pulse();
        chk("t2_holdlo1_phase", phase, 4);
        pulse();
        chk("t2_reup_phase", phase, 1);
        chk("t2_reup_level", level, 0);

        // PWM at level 5: 5 contiguous highs in every 15 clocks
        for (int i = 0; i < 5; i++) pulse();
        chk("t3_level5", level, 5);
        wait_clks(30);
        for (int w = 0; w < 3; w++) begin
            sample_led(15, hi, rises);
            chk("t3_duty5_high", hi, 5);
            chk("t3_duty5_rises", rises, 1);
        end

        // level 15 -> constant high
        for (int i = 0; i < 10; i++) pulse();
        chk("t3_level15", level, 15);
        chk("t3_hold_phase", phase, 2);
        wait_clks(30);
        sample_led(30, hi, rises);
        chk("t3_duty15_high", hi, 30);

        // level 0 -> constant low
        for (int i = 0; i < 17; i++) pulse();
        chk("t3_level0", level, 0);
        chk("t3_holdlo_phase", phase, 4);
        wait_clks(30);
        sample_led(30, hi, rises);
        chk("t3_duty0_high", hi, 0);

        // fade-out from level 7 in UP
        pulse();
        pulse();
        chk("t5_up_phase", phase, 1);
        for (int i = 0; i < 7; i++) pulse();
        chk("t5_level7", level, 7);
        en = 1'b0;
        clk1();
        chk("t5_fade_phase", phase, 3);
        chk("t5_fade_level", level, 7);
        for (int i = 1; i <= 7; i++) begin
            pulse();
            chk("t5_dn_level", level, 7 - i);
        end
        chk("t5_holdlo_phase", phase, 4);
        clk1();
        chk("t5_idle_phase", phase, 0);
        chk("t5_idle_busy", busy, 0);
        wait_clks(30);
        sample_led(15, hi, rises);
        chk("t5_idle_led_high", hi, 0);

        // reset at level 9 in DOWN with a tick pending
        en = 1'b1;
        clk1();
        chk("t6_up_phase", phase, 1);
        ramp_up("t6a");
        pulse();
        pulse();
        chk("t6_down_phase", phase, 3);
        for (int i = 0; i < 6; i++) pulse();
        chk("t6_level9", level, 9);
        rst_n = 1'b0;
        tick  = 1'b1;
        clk1();
        chk("t6_rst_level", level, 0);
        chk("t6_rst_phase", phase, 0);
        chk("t6_rst_led",   led,   0);
        rst_n = 1'b1;
        tick  = 1'b0;
        clk1();
        chk("t6_restart_phase", phase, 1);
        ramp_up("t6b");

        // STEP=4 saturation at both ends
        en4 = 1'b1;
        clk1();
        chk("t4_up_phase", phase4, 1);
        for (int i = 0; i < 4; i++) begin
            pulse4();
            chk("t4_up_level", level4, up_lv[i]);
        end
        chk("t4_hold_phase", phase4, 2);
        pulse4();
        pulse4();
        chk("t4_down_phase", phase4, 3);
        for (int i = 0; i < 4; i++) begin
            pulse4();
            chk("t4_dn_level", level4, dn_lv[i]);
        end
        chk("t4_holdlo_phase", phase4, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
